// File: rtl/aud_tx_stm_if.sv
`default_nettype none
// ============================================================================
// Module   : aud_tx_stm_if
// Purpose  : Sample-producer write port plus downstream RTS/RTR stream port.
// Revision : 1.0 - initial release
// ============================================================================
interface aud_tx_stm_if #(
   parameter int AW = 3
);
   logic          wr_en;
   logic [15:0]   wr_data;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;
   logic          rts;
   logic          rtr;
   logic [15:0]   aud_out;

   modport slave (
      input  wr_en, wr_data, rtr,
      output full, count, overflow, rts, aud_out
   );

   modport master (
      output wr_en, wr_data, rtr,
      input  full, count, overflow, rts, aud_out
   );
endinterface
`default_nettype wire

// File: rtl/aud_tx_stm.sv
`default_nettype none
// ============================================================================
// Module   : aud_tx_stm
// Purpose  : Audio sample FIFO feeding a paced RTS/RTR stream transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module aud_tx_stm #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         enable,
   input  logic [7:0]   rf_sample_period,
   aud_tx_stm_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_e        state_q, state_d;
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    gap_q, gap_d;
   logic          rts_q, rts_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   aud_q, aud_d;
   logic          do_pop;
   logic          do_wr;

   // A write into a full FIFO is still taken when the head leaves the same cycle.
   always_comb begin
      do_pop = (state_q == IDLE) && enable && (count_q != '0);
      do_wr  = bus.wr_en && ((count_q != FULL_CNT) || do_pop);
   end

   always_comb begin
      state_d = state_q;
      rts_d   = rts_q;
      aud_d   = aud_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            if (do_pop) begin
               aud_d   = mem_q[rd_ptr_q];
               rts_d   = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (bus.rtr) begin
               rts_d   = 1'b0;
               gap_d   = rf_sample_period;
               state_d = (rf_sample_period != 8'd0) ? GAP : IDLE;
            end
         end
         GAP: begin
            gap_d = gap_q - 8'd1;
            if (gap_q <= 8'd1) begin
               gap_d   = 8'd0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = do_wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      ovf_d    = ovf_q | (bus.wr_en & ~do_wr);
      count_d  = count_q;
      case ({do_wr, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         gap_q    <= '0;
         rts_q    <= 1'b0;
         ovf_q    <= 1'b0;
         aud_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         rts_q    <= rts_d;
         ovf_q    <= ovf_d;
         aud_q    <= aud_d;
      end
   end

   // Storage is not reset; occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.rts      = rts_q;
   assign bus.aud_out  = aud_q;
   assign bus.count    = count_q;
   assign bus.full     = (count_q == FULL_CNT);
   assign bus.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_aud_tx_stm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aud_tx_stm
// Purpose  : Vector table, scoreboard and directed sequences for aud_tx_stm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aud_tx_stm;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic       clk    = 1'b0;
   logic       rstb   = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] period = 8'd0;

   always #5 clk = ~clk;

   aud_tx_stm_if #(.AW(AW)) bus ();

   aud_tx_stm #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk              (clk),
      .rstb             (rstb),
      .enable           (enable),
      .rf_sample_period (period),
      .bus              (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] sb [$];
   int          rise_t [$];
   int          cyc_n    = 0;
   int          max_cnt  = 0;
   logic        rts_prev = 1'b0;
   logic [15:0] exp_w;

   typedef struct {
      logic        wr_en;
      logic [15:0] wr_data;
      logic        rtr;
      logic        exp_rts;
      logic [15:0] exp_aud;
      logic [3:0]  exp_cnt;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int lim);
      int k = 0;
      while ((sb.size() != 0 || bus.rts) && k < lim) begin
         cyc();
         k++;
      end
      chk(name, 32'(k < lim), 32'd1);
   endtask

   // Transfer monitor: rts&rtr seen mid-cycle means a transfer on the coming edge.
   always @(negedge clk) begin
      cyc_n++;
      if (rstb) begin
         if (bus.rts && !rts_prev) rise_t.push_back(cyc_n);
         if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
         if (bus.rts && bus.rtr) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL xfer_unexpected: got 0x%0h, expected no transfer", bus.aud_out);
            end else begin
               exp_w = sb.pop_front();
               chk("xfer_data", 32'(bus.aud_out), 32'(exp_w));
            end
         end
      end
      rts_prev = bus.rts;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b1, 16'h0004, 1'b1, 1'b0, 16'h0000, 4'd1};
      vt[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 4'd0};
      vt[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 4'd0};
      vt[3] = '{1'b1, 16'h0009, 1'b0, 1'b0, 16'h0004, 4'd1};
      vt[4] = '{1'b1, 16'h000C, 1'b0, 1'b1, 16'h0009, 4'd1};
      vt[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0009, 4'd1};
      vt[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0009, 4'd1};
      vt[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 4'd1};
      vt[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 4'd0};
      vt[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h000C, 4'd0};

      bus.wr_en   = 1'b0;
      bus.wr_data = 16'h0;
      bus.rtr     = 1'b0;
      repeat (3) cyc();
      chk("rst_rts",   32'(bus.rts),      32'd0);
      chk("rst_aud",   32'(bus.aud_out),  32'd0);
      chk("rst_count", 32'(bus.count),    32'd0);
      chk("rst_full",  32'(bus.full),     32'd0);
      chk("rst_ovf",   32'(bus.overflow), 32'd0);
      rstb   = 1'b1;
      enable = 1'b1;
      period = 8'd0;

      // Single sample followed by backpressure
      for (int i = 0; i < 10; i++) begin
         bus.wr_en   = vt[i].wr_en;
         bus.wr_data = vt[i].wr_data;
         bus.rtr     = vt[i].rtr;
         if (vt[i].wr_en) sb.push_back(vt[i].wr_data);
         cyc();
         bus.wr_en = 1'b0;
         chk($sformatf("vec%0d_rts", i),   32'(bus.rts),     32'(vt[i].exp_rts));
         chk($sformatf("vec%0d_aud", i),   32'(bus.aud_out), 32'(vt[i].exp_aud));
         chk($sformatf("vec%0d_count", i), 32'(bus.count),   32'(vt[i].exp_cnt));
      end
      chk("bp_drained", 32'(sb.size()), 32'd0);

      // Pacing with a 3-cycle gap
      period = 8'd3;
      bus.rtr = 1'b1;
      rise_t.delete();
      foreach (vt[i]) begin end
      bus.wr_en = 1'b1;
      bus.wr_data = 16'd7; sb.push_back(16'd7); cyc();
      bus.wr_data = 16'd5; sb.push_back(16'd5); cyc();
      bus.wr_data = 16'd8; sb.push_back(16'd8); cyc();
      bus.wr_en = 1'b0;
      wait_drain("pace_drain", 100);
      chk("pace_rises", 32'(rise_t.size()), 32'd3);
      if (rise_t.size() == 3) begin
         chk("pace_gap1", 32'(rise_t[1] - rise_t[0]), 32'd5);
         chk("pace_gap2", 32'(rise_t[2] - rise_t[1]), 32'd5);
      end

      // Fill past capacity with the transmitter blocked
      period = 8'd0;
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 16'(16'h0100 + i);
         if (i < DEPTH) sb.push_back(16'(16'h0100 + i));
         cyc();
      end
      bus.wr_en = 1'b0;
      chk("full_flag",  32'(bus.full),     32'd1);
      chk("full_count", 32'(bus.count),    32'd8);
      chk("full_ovf",   32'(bus.overflow), 32'd1);
      enable = 1'b1;
      wait_drain("full_drain", 100);
      repeat (4) cyc();
      chk("full_ovf_sticky", 32'(bus.overflow), 32'd1);
      chk("full_empty",      32'(bus.count),    32'd0);

      // Streaming 20 samples, one write every two cycles
      max_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 16'(16'h2000 + i * 3);
         sb.push_back(16'(16'h2000 + i * 3));
         cyc();
         bus.wr_en = 1'b0;
         cyc();
      end
      wait_drain("wrap_drain", 100);
      chk("wrap_max_count", 32'(max_cnt <= 1), 32'd1);

      // Asynchronous reset while offering with three samples queued
      enable  = 1'b0;
      bus.rtr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 16'(16'hA0 + i);
         cyc();
      end
      bus.wr_en = 1'b0;
      enable = 1'b1;
      cyc();
      chk("pre_rst_rts",   32'(bus.rts),   32'd1);
      chk("pre_rst_count", 32'(bus.count), 32'd3);
      #2;
      rstb = 1'b0;
      #1;
      chk("async_rst_rts",   32'(bus.rts),      32'd0);
      chk("async_rst_aud",   32'(bus.aud_out),  32'd0);
      chk("async_rst_count", 32'(bus.count),    32'd0);
      chk("async_rst_ovf",   32'(bus.overflow), 32'd0);
      chk("async_rst_full",  32'(bus.full),     32'd0);
      cyc();
      rstb    = 1'b1;
      bus.rtr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("post_rst_rts%0d", i), 32'(bus.rts), 32'd0);
      end
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'h0055;
      sb.push_back(16'h0055);
      cyc();
      bus.wr_en = 1'b0;
      wait_drain("post_rst_drain", 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
